// File: rtl/tone_sequencer.sv
// tone_sequencer: plays each tone selected by a 5-bit mask in order (tone 1 first),
// as fixed-length square-wave bursts separated by silent gaps.
module tone_sequencer #(
    parameter int HALF1       = 25_000,
    parameter int HALF2       = 12_500,
    parameter int HALF3       = 8_333,
    parameter int HALF4       = 6_250,
    parameter int HALF5       = 5_000,
    parameter int TONE_CYCLES = 30_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [4:0] tone_mask,
    output logic       tone_out,
    output logic       busy,
    output logic       done,
    output logic [4:0] active
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TONE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  pending, cur, rest;
    logic [31:0] phase, dur, half;
    logic        phase_end, tone_end, gap_end;

    function automatic logic [4:0] first_hot(input logic [4:0] m);
        first_hot = m[4] ? 5'b10000 : m[3] ? 5'b01000 : m[2] ? 5'b00100 :
                    m[1] ? 5'b00010 : m[0] ? 5'b00001 : 5'b00000;
    endfunction

    always_comb begin
        half      = cur[4] ? 32'(HALF1) : cur[3] ? 32'(HALF2) : cur[2] ? 32'(HALF3) :
                    cur[1] ? 32'(HALF4) : 32'(HALF5);
        rest      = pending & ~cur;
        phase_end = phase == half - 32'd1;
        tone_end  = dur == 32'(TONE_CYCLES - 1);
        gap_end   = dur == 32'(GAP_CYCLES - 1);
        busy      = state != IDLE;
        active    = state == TONE ? cur : 5'b0;
        done      = state == TONE && tone_end && rest == 5'b0 && !stop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            cur      <= '0;
            phase    <= '0;
            dur      <= '0;
            tone_out <= 1'b0;
        end else if (stop) begin
            state    <= IDLE;
            pending  <= '0;
            cur      <= '0;
            phase    <= '0;
            dur      <= '0;
            tone_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && tone_mask != 5'b0) begin
                    state    <= TONE;
                    pending  <= tone_mask;
                    cur      <= first_hot(tone_mask);
                    phase    <= '0;
                    dur      <= '0;
                    tone_out <= 1'b0;
                end
                TONE: if (tone_end) begin
                    // every tone must start low, so the generator is cleared at the boundary
                    pending  <= rest;
                    state    <= rest != 5'b0 ? GAP : IDLE;
                    cur      <= rest != 5'b0 ? cur : 5'b0;
                    phase    <= '0;
                    dur      <= '0;
                    tone_out <= 1'b0;
                end else begin
                    phase    <= phase_end ? 32'd0 : phase + 32'd1;
                    tone_out <= phase_end ? ~tone_out : tone_out;
                    dur      <= dur + 32'd1;
                end
                GAP: if (gap_end) begin
                    state <= TONE;
                    cur   <= first_hot(pending);
                    dur   <= '0;
                end else begin
                    dur <= dur + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of tone order, waveform, gaps, abort, reset and back-to-back starts.
module tb_tone_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] tone_mask = 5'b0;
    logic       tone_out, busy, done;
    logic [4:0] active;
    int         total = 0;
    int         bad = 0;

    tone_sequencer #(
        .HALF1(2), .HALF2(3), .HALF3(4), .HALF4(5), .HALF5(6),
        .TONE_CYCLES(20), .GAP_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .tone_mask(tone_mask), .tone_out(tone_out), .busy(busy),
        .done(done), .active(active)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_tone"}, 32'(tone_out), 0);
    endtask

    // checks n cycles of a tone starting at cycle 0 of the burst
    task automatic play(input string tag, input logic [4:0] hot, input int half, input int n, input bit last);
        int rises = 0;
        logic prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tone"}, 32'(tone_out), 32'((i / half) % 2));
            chk({tag, "_active"}, 32'(active), 32'(hot));
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_done"}, 32'(done), 32'(last && i == 19));
            if (tone_out && !prev) rises++;
            prev = tone_out;
            if (i < n - 1 || n == 20) step();
        end
        if (n == 20) chk({tag, "_rises"}, 32'(rises), 32'((20 + 2 * half - 1 - half) / (2 * half)));
    endtask

    task automatic gap(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_tone"}, 32'(tone_out), 0);
            chk({tag, "_active"}, 32'(active), 0);
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_done"}, 32'(done), 0);
            step();
        end
    endtask

    task automatic go(input logic [4:0] m);
        tone_mask = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #2;
        idle_chk("reset");
        step();
        reset = 1'b0;
        step();
        idle_chk("post_reset");

        // single tone 1: period 4, 5 rising edges, done on cycle 20
        go(5'b10000);
        play("t1_single", 5'b10000, 2, 20, 1'b1);
        idle_chk("t1_end");

        // empty mask is ignored
        go(5'b00000);
        idle_chk("zero_mask");
        step();
        idle_chk("zero_mask2");

        // tones 1,3,5 with a late start request during a gap that must be dropped
        go(5'b10101);
        play("multi_t1", 5'b10000, 2, 20, 1'b0);
        tone_mask = 5'b00001;
        start = 1'b1;
        gap("multi_gap1");
        start = 1'b0;
        tone_mask = 5'b0;
        play("multi_t3", 5'b00100, 4, 20, 1'b0);
        gap("multi_gap2");
        play("multi_t5", 5'b00001, 6, 20, 1'b1);
        idle_chk("multi_end");
        step();
        idle_chk("multi_no_extra");

        // abort on cycle 10 of tone 2
        go(5'b01001);
        play("abort_t2", 5'b01000, 3, 11, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        idle_chk("abort_next");
        for (int i = 0; i < 30; i++) begin
            chk("abort_quiet_busy", 32'(busy), 0);
            chk("abort_quiet_active", 32'(active), 0);
            step();
        end

        // stop beats a simultaneous start
        tone_mask = 5'b10000;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        idle_chk("start_stop");

        // asynchronous reset mid-tone
        go(5'b10000);
        play("pre_reset", 5'b10000, 2, 4, 1'b0);
        chk("pre_reset_high", 32'(tone_out), 1);
        #2 reset = 1'b1;
        #1 idle_chk("async_reset");
        @(negedge clock);
        reset = 1'b0;
        step();
        idle_chk("after_reset");
        go(5'b00010);
        play("t4_fresh", 5'b00010, 5, 20, 1'b1);

        // back-to-back start in the first idle cycle
        chk("b2b_busy_low", 32'(busy), 0);
        go(5'b00001);
        play("b2b_t5", 5'b00001, 6, 20, 1'b1);
        idle_chk("b2b_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Transmit-side companion to the band-pass tone detector: it generates square-wave tones at five fixed frequencies, one per detector channel (tone 1..5 ↔ bp1..bp5), on a single output that drives the speaker/DAC path. A 5-bit mask starts the burst. The block plays each selected tone in order, tone 1 first, for a fixed duration that exceeds the detector's 25_000_000-cycle qualification time. A silent gap separates consecutive tones. Handshake is start/busy/done toward the control logic; `active` mirrors the tone currently playing so it can drive LEDs.

## Interface
- HALF1, 25_000: half-period in clock cycles of tone 1 (1 kHz at 50 MHz)
- HALF2, 12_500: half-period of tone 2
- HALF3, 8_333: half-period of tone 3
- HALF4, 6_250: half-period of tone 4
- HALF5, 5_000: half-period of tone 5
- TONE_CYCLES, 30_000_000: cycles each tone is played
- GAP_CYCLES, 5_000_000: silent cycles between consecutive tones
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse, sampled only in IDLE
- stop  in  1  synchronous abort, takes priority over everything except reset
- tone_mask  in  5  bit 4 = tone 1 … bit 0 = tone 5
- tone_out  out  1  square-wave output
- busy  out  1  high from the cycle after an accepted start until the sequence ends
- done  out  1  one-cycle pulse on normal completion
- active  out  5  one-hot tone currently sounding, same bit order as tone_mask; 0 in IDLE/GAP

## Operation
- Parameter constraints: all HALFn ≥ 1, TONE_CYCLES ≥ 1, GAP_CYCLES ≥ 1. Counters are 32 bits wide.
- The FSM has three states: IDLE, TONE, GAP.
- **IDLE**
  - Outputs are quiescent: tone_out=0, busy=0, active=0.
  - start=1 with tone_mask≠0 latches the mask into `pending`, then moves to TONE on the highest set bit.
  - start with tone_mask=0 is ignored: no busy, no done.
- **TONE, tone n**
  - active=one-hot(n).
  - Phase counter counts 0..HALFn−1. At HALFn−1, tone_out toggles and the phase counter returns to 0.
  - Duration counter counts 0..TONE_CYCLES−1.
  - On the last duration cycle, bit n is cleared from `pending`.
  - Next state: GAP if `pending` is still nonzero; otherwise IDLE with done=1 for that one cycle.
- **GAP**
  - tone_out=0, active=0.
  - Counts GAP_CYCLES cycles, then enters TONE on the highest remaining set bit.
- On entry to TONE, the phase counter is 0 and tone_out=0, so every tone starts low.
- start and tone_mask are ignored while busy. The latched `pending` is the only sequence source.
- stop=1 in any state:
  - next cycle is IDLE with all outputs 0 and `pending` cleared;
  - no done pulse;
  - stop in IDLE has no effect.
  - Simultaneous start and stop in IDLE: stop wins and start is dropped.
- Reset, asserted at any time including mid-tone, immediately forces IDLE with all counters, `pending` and outputs at 0.

## Timing
- Reset value of every output is 0.
- start sampled high at edge N: busy=1, the TONE state and active are valid from cycle N+1, and tone_out=0 at N+1.
- First rising edge of tone_out: HALFn cycles after TONE entry. Period is 2·HALFn cycles. Duty cycle is 50% when TONE_CYCLES is a multiple of 2·HALFn.
- Each tone occupies exactly TONE_CYCLES cycles. Each gap occupies exactly GAP_CYCLES cycles.
- Total busy time for k selected tones: k·TONE_CYCLES + (k−1)·GAP_CYCLES cycles.
- done is high on the last TONE cycle, not after it. busy and active are 0 from the next cycle.
- A new start is accepted on the first cycle busy=0, i.e. back-to-back sequences have no dead cycle beyond IDLE.

## Test plan
Bench parameters: HALF1..5 = 2,3,4,5,6; TONE_CYCLES=20; GAP_CYCLES=4.

1. **Single tone:** tone_mask=5'b10000, start pulse.
   - busy for 20 cycles and active=5'b10000 throughout.
   - tone_out=0,0,1,1,0,0,… (period 4), giving 5 rising edges.
   - done on cycle 20 only.
2. **Multi-tone:** mask=5'b10101.
   - Tones 1, 3, 5 play in that order, separated by 4-cycle gaps with tone_out=0 and active=0.
   - Tone 3 period is 8 cycles; tone 5 period is 12 cycles.
   - busy lasts 68 cycles.
3. **Ignored requests:**
   - start with mask=0 leaves busy=0 and done=0.
   - start with mask=5'b00001 issued mid-sequence is not played.
4. **Abort:** stop asserted on cycle 10 of tone 2 with mask=5'b01001.
   - Next cycle: tone_out=0, busy=0, active=0.
   - No done pulse, and tone 5 never plays.
5. **Reset mid-tone:** assert reset asynchronously between clock edges during a tone.
   - All outputs drop to 0 without waiting for a clock edge.
   - After release, a fresh start with mask=5'b00010 plays tone 4 from phase 0.
6. **Back-to-back:** start with mask=5'b00001 in the cycle after done.
   - It is accepted with no gap: busy goes 1 → 0 → 1.
   - Tone 5 then plays for 20 cycles.
